pcie_line_rd_buf: RTL and testbench

- Parametrised successor to the single-bank DDR-to-PCIe read buffer.
- Fetches one video frame line-by-line from DDR into a LINE_BANKS-deep ring of line banks and serves it to the PCIe MWr path as OUT_WIDTH words under valid/ready back-pressure.
- Supports FRAME_BUF_NUM frame slots, prefetches ahead while banks are free, and handles frame aborts cleanly.
- Single-clock block in the DDR clock domain; PCIe-side CDC is handled upstream.

---
 rtl/pcie_line_rd_buf.sv | 268 ++++++++++++++++++++++++++
 tb/tb_pcie_line_rd_buf.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_line_rd_buf.sv
// pcie_line_rd_buf: fetches a video frame line by line from DDR into a ring of
// LINE_BANKS line banks and streams it out as OUT_WIDTH words under
// valid/ready back-pressure. Single clock (ddr_clk), synchronous active-low reset.
//
// Optional build macro PCIE_LINE_RD_BUF_STALL_CNT_EN adds o_stall_cnt, a
// saturating count of cycles where a word is offered but not accepted.
//
// Fetch FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no frame in progress, no request outstanding
//   ST_REQ   | ddr_rreq presented at ddr_raddr, waiting for ddr_rrdy
//   ST_DATA  | read accepted, beats land in bank wr_bank; wait_bank=1 means
//            | the line is committed and the next request waits for a free bank
//   ST_DRAIN | frame aborted mid-read, beats discarded until ddr_rdone
module pcie_line_rd_buf #(
    parameter int          ADDR_WIDTH       = 27,
    parameter logic [31:0] ADDR_OFFSET      = 32'h0,
    parameter int          H_NUM            = 1920,
    parameter int          V_NUM            = 1080,
    parameter int          PIX_WIDTH        = 16,
    parameter int          DQ_WIDTH         = 32,
    parameter int          LEN_WIDTH        = 16,
    parameter int          OUT_WIDTH        = 128,
    parameter int          LINE_BANKS       = 2,
    parameter int          FRAME_BUF_NUM    = 4,
    parameter int          FRAME_ADDR_SHIFT = 20
) (
    input  logic                       ddr_clk,
    input  logic                       ddr_rstn,
    input  logic                       frame_start,
    input  logic [((FRAME_BUF_NUM > 1) ? $clog2(FRAME_BUF_NUM) : 1)-1:0] frame_sel,
    output logic                       ddr_rreq,
    output logic [ADDR_WIDTH-1:0]      ddr_raddr,
    output logic [LEN_WIDTH-1:0]       ddr_rd_len,
    input  logic                       ddr_rrdy,
    input  logic                       ddr_rdone,
    input  logic [8*DQ_WIDTH-1:0]      ddr_rdata,
    input  logic                       ddr_rdata_en,
    output logic [OUT_WIDTH-1:0]       o_data,
    output logic                       o_data_valid,
    input  logic                       i_data_ready,
    output logic                       o_line_end,
    output logic                       o_frame_end,
    output logic [1:0]                 o_err
`ifdef PCIE_LINE_RD_BUF_STALL_CNT_EN
    ,
    output logic [31:0]                o_stall_cnt
`endif
);

    localparam int DW         = 8 * DQ_WIDTH;
    localparam int LINE_BEATS = H_NUM * PIX_WIDTH / DW;
    localparam int LINE_STEP  = LINE_BEATS * 8;
    localparam int RATIO      = DW / OUT_WIDTH;
    localparam int BKW        = $clog2(LINE_BANKS);
    localparam int BW         = $clog2(LINE_BEATS + 1);
    localparam int LW         = $clog2(V_NUM + 1);
    localparam int SW         = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DEPTH      = LINE_BANKS * LINE_BEATS;
    localparam int MAW        = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA, ST_DRAIN} state_t;

    state_t                 state;
    logic                   wait_bank;
    logic [LW-1:0]          line;
    logic [BW-1:0]          wr_beat;
    logic [BKW-1:0]         wr_bank;
    logic [LINE_BANKS-1:0]  bank_full;
    logic [DW-1:0]          mem [DEPTH];

    logic [BKW-1:0]         rd_bank;
    logic [BW-1:0]          rd_beat;
    logic [SW-1:0]          rd_sub;
    logic [LW-1:0]          out_line;
    logic [BKW-1:0]         out_bank;

    logic [BKW-1:0]         wr_bank_nx;
    logic                   free_en;
    logic                   nx_empty;
    logic                   cur_empty;
    logic                   beat_wr;
    logic [BW-1:0]          beats_now;
    logic                   rd_outstanding;
    logic [MAW-1:0]         wr_addr;
    logic [MAW-1:0]         rd_addr;
    logic [DW-1:0]          rd_word;
    logic                   load;
    logic                   sub_last;
    logic                   beat_last;

    // A bank is released when the consumer takes its last word; the writer may
    // reuse it in that same cycle.
    assign free_en        = o_data_valid && i_data_ready && o_line_end;
    assign wr_bank_nx     = wr_bank + 1'b1;
    assign nx_empty       = !bank_full[wr_bank_nx] || (free_en && (out_bank == wr_bank_nx));
    assign cur_empty      = !bank_full[wr_bank] || (free_en && (out_bank == wr_bank));
    assign beat_wr        = (state == ST_DATA) && !wait_bank && ddr_rdata_en &&
                            (wr_beat < BW'(LINE_BEATS)) && !frame_start;
    assign beats_now      = wr_beat + BW'(beat_wr);
    assign rd_outstanding = ((state == ST_DATA) && !wait_bank) || (state == ST_DRAIN) ||
                            ((state == ST_REQ) && ddr_rreq && ddr_rrdy);
    assign wr_addr        = MAW'(wr_bank) * MAW'(LINE_BEATS) + MAW'(wr_beat);
    assign rd_addr        = MAW'(rd_bank) * MAW'(LINE_BEATS) + MAW'(rd_beat);
    assign rd_word        = mem[rd_addr];
    assign load           = !o_data_valid || i_data_ready;
    assign sub_last       = (rd_sub == SW'(RATIO - 1));
    assign beat_last      = (rd_beat == BW'(LINE_BEATS - 1));

    // Line bank storage; beats past LINE_BEATS never reach it.
    always_ff @(posedge ddr_clk) begin
        if (beat_wr) mem[wr_addr] <= ddr_rdata;
    end

    // Fetch FSM, bank occupancy and error flags.
    always_ff @(posedge ddr_clk) begin
        if (!ddr_rstn) begin
            state      <= ST_IDLE;
            wait_bank  <= 1'b0;
            line       <= '0;
            wr_beat    <= '0;
            wr_bank    <= '0;
            bank_full  <= '0;
            ddr_rreq   <= 1'b0;
            ddr_raddr  <= '0;
            ddr_rd_len <= '0;
            o_err      <= 2'b00;
        end else begin
            ddr_rd_len <= LEN_WIDTH'(LINE_BEATS);
            if (frame_start) begin
                bank_full <= '0;
                o_err     <= 2'b00;
                line      <= '0;
                wr_beat   <= '0;
                wr_bank   <= '0;
                wait_bank <= 1'b0;
                ddr_raddr <= ADDR_WIDTH'(ADDR_OFFSET) +
                             (ADDR_WIDTH'(frame_sel) << FRAME_ADDR_SHIFT);
                if (rd_outstanding && !ddr_rdone) begin
                    // a read is in flight: swallow it before restarting
                    state    <= ST_DRAIN;
                    ddr_rreq <= 1'b0;
                end else if ((state == ST_REQ) && ddr_rreq) begin
                    // withdraw the old request, re-raise with the new address
                    state    <= ST_REQ;
                    ddr_rreq <= 1'b0;
                end else begin
                    state    <= ST_REQ;
                    ddr_rreq <= 1'b1;
                end
            end else begin
                for (int i = 0; i < LINE_BANKS; i++) begin
                    if (free_en && (out_bank == BKW'(i))) bank_full[i] <= 1'b0;
                end
                case (state)
                    ST_IDLE: begin
                    end
                    ST_REQ: begin
                        if (!ddr_rreq) begin
                            ddr_rreq <= 1'b1;
                        end else if (ddr_rrdy) begin
                            ddr_rreq <= 1'b0;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (wait_bank) begin
                            if (cur_empty) begin
                                wait_bank <= 1'b0;
                                state     <= ST_REQ;
                                ddr_rreq  <= 1'b1;
                            end
                        end else begin
                            if (beat_wr) begin
                                wr_beat <= wr_beat + 1'b1;
                            end else if (ddr_rdata_en) begin
                                o_err[0] <= 1'b1;
                            end
                            if (ddr_rdone) begin
                                bank_full[wr_bank] <= 1'b1;
                                if (beats_now < BW'(LINE_BEATS)) o_err[1] <= 1'b1;
                                wr_beat <= '0;
                                wr_bank <= wr_bank_nx;
                                line    <= line + 1'b1;
                                if (line == LW'(V_NUM - 1)) begin
                                    state <= ST_IDLE;
                                end else begin
                                    ddr_raddr <= ddr_raddr + ADDR_WIDTH'(LINE_STEP);
                                    if (nx_empty) begin
                                        state    <= ST_REQ;
                                        ddr_rreq <= 1'b1;
                                    end else begin
                                        wait_bank <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (ddr_rdone) begin
                            state    <= ST_REQ;
                            ddr_rreq <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Output stage: one registered word, refilled whenever empty or accepted.
    always_ff @(posedge ddr_clk) begin
        if (!ddr_rstn) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_line_end   <= 1'b0;
            o_frame_end  <= 1'b0;
            rd_bank      <= '0;
            rd_beat      <= '0;
            rd_sub       <= '0;
            out_line     <= '0;
            out_bank     <= '0;
        end else if (frame_start) begin
            o_data_valid <= 1'b0;
            o_line_end   <= 1'b0;
            o_frame_end  <= 1'b0;
            rd_bank      <= '0;
            rd_beat      <= '0;
            rd_sub       <= '0;
            out_line     <= '0;
        end else if (load) begin
            if (bank_full[rd_bank]) begin
                o_data       <= rd_word[rd_sub*OUT_WIDTH +: OUT_WIDTH];
                o_data_valid <= 1'b1;
                o_line_end   <= sub_last && beat_last;
                o_frame_end  <= sub_last && beat_last && (out_line == LW'(V_NUM - 1));
                out_bank     <= rd_bank;
                rd_sub       <= sub_last ? '0 : rd_sub + 1'b1;
                if (sub_last) begin
                    if (beat_last) begin
                        rd_beat  <= '0;
                        rd_bank  <= rd_bank + 1'b1;
                        out_line <= (out_line == LW'(V_NUM - 1)) ? '0 : out_line + 1'b1;
                    end else begin
                        rd_beat <= rd_beat + 1'b1;
                    end
                end
            end else begin
                o_data_valid <= 1'b0;
                o_line_end   <= 1'b0;
                o_frame_end  <= 1'b0;
            end
        end
    end

`ifdef PCIE_LINE_RD_BUF_STALL_CNT_EN
    // Saturating count of back-pressured cycles.
    always_ff @(posedge ddr_clk) begin
        if (!ddr_rstn || frame_start) begin
            o_stall_cnt <= '0;
        end else if (o_data_valid && !i_data_ready && (o_stall_cnt != 32'hFFFF_FFFF)) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pcie_line_rd_buf.sv
// Testbench for pcie_line_rd_buf: H_NUM=64, PIX_WIDTH=16, V_NUM=3 gives
// 4 beats per line, 2 words per beat, line step 0x20.
module tb_pcie_line_rd_buf;

    logic         ddr_clk = 1'b0;
    logic         ddr_rstn;
    logic         frame_start;
    logic [1:0]   frame_sel;
    logic         ddr_rreq;
    logic [26:0]  ddr_raddr;
    logic [15:0]  ddr_rd_len;
    logic         ddr_rrdy;
    logic         ddr_rdone;
    logic [255:0] ddr_rdata;
    logic         ddr_rdata_en;
    logic [127:0] o_data;
    logic         o_data_valid;
    logic         i_data_ready;
    logic         o_line_end;
    logic         o_frame_end;
    logic [1:0]   o_err;
`ifdef PCIE_LINE_RD_BUF_STALL_CNT_EN
    logic [31:0]  o_stall_cnt;
`endif

    pcie_line_rd_buf #(.H_NUM(64), .V_NUM(3), .PIX_WIDTH(16)) dut (
        .ddr_clk      (ddr_clk),
        .ddr_rstn     (ddr_rstn),
        .frame_start  (frame_start),
        .frame_sel    (frame_sel),
        .ddr_rreq     (ddr_rreq),
        .ddr_raddr    (ddr_raddr),
        .ddr_rd_len   (ddr_rd_len),
        .ddr_rrdy     (ddr_rrdy),
        .ddr_rdone    (ddr_rdone),
        .ddr_rdata    (ddr_rdata),
        .ddr_rdata_en (ddr_rdata_en),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_line_end   (o_line_end),
        .o_frame_end  (o_frame_end),
        .o_err        (o_err)
`ifdef PCIE_LINE_RD_BUF_STALL_CNT_EN
        ,
        .o_stall_cnt  (o_stall_cnt)
`endif
    );

    always #5 ddr_clk = ~ddr_clk;

    typedef struct packed {
        logic [127:0] d;
        logic         dc;
        logic         le;
        logic         fe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rx_cnt = 0;
    int   beat_id = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every accepted word must match the head of the queue.
    always @(negedge ddr_clk) begin
        if (ddr_rstn && o_data_valid && i_data_ready) begin
            exp_t e;
            rx_cnt++;
            chk("word_expected", 256'(sb.size() != 0), 256'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (!e.dc) chk("o_data", 256'(o_data), 256'(e.d));
                chk("o_line_end", 256'(o_line_end), 256'(e.le));
                chk("o_frame_end", 256'(o_frame_end), 256'(e.fe));
            end
        end
    end

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    function automatic logic [255:0] mk_beat(input int id);
        logic [255:0] b;
        for (int j = 0; j < 8; j++) b[j*32 +: 32] = 32'(id * 8 + j) ^ 32'hC3A5_0000;
        return b;
    endfunction

    task automatic push_beat(input logic [255:0] b, input logic last, input int line_idx,
                             input logic dc);
        exp_t e;
        e.d = b[127:0];   e.dc = dc; e.le = 1'b0; e.fe = 1'b0;
        sb.push_back(e);
        e.d = b[255:128]; e.dc = dc; e.le = last; e.fe = last && (line_idx == 2);
        sb.push_back(e);
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        frame_sel   = sel;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic req_phase(input logic [26:0] addr, input int hold);
        logic found = 1'b0;
        if (hold == 0) ddr_rrdy = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            if (ddr_rreq) found = 1'b1;
            else tick();
        end
        chk("req_seen", 256'(found), 256'd1);
        if (found) begin
            chk("req_addr", 256'(ddr_raddr), 256'(addr));
            chk("req_len", 256'(ddr_rd_len), 256'd4);
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("hold_rreq", 256'(ddr_rreq), 256'd1);
                chk("hold_addr", 256'(ddr_raddr), 256'(addr));
            end
            ddr_rrdy = 1'b1;
            tick();
            chk("req_drop", 256'(ddr_rreq), 256'd0);
        end
    endtask

    task automatic beats_phase(input int n, input int line_idx, input logic push);
        logic [255:0] b;
        for (int k = 0; k < n; k++) begin
            b = mk_beat(beat_id);
            beat_id++;
            ddr_rdata    = b;
            ddr_rdata_en = 1'b1;
            if (push && k < 4) push_beat(b, k == 3, line_idx, 1'b0);
            tick();
        end
        ddr_rdata_en = 1'b0;
        ddr_rdone    = 1'b1;
        tick();
        ddr_rdone = 1'b0;
        if (push) begin
            for (int k = n; k < 4; k++) push_beat('0, k == 3, line_idx, 1'b1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        chk("drain_done", 256'(sb.size()), 256'd0);
        repeat (3) tick();
    endtask

    task automatic idle_check(input int n);
        logic seen = 1'b0;
        repeat (n) begin
            tick();
            if (ddr_rreq) seen = 1'b1;
        end
        chk("idle_no_req", 256'(seen), 256'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_o_data"},   256'(o_data), 256'd0);
        chk({tag, "_valid"},    256'(o_data_valid), 256'd0);
        chk({tag, "_line_end"}, 256'(o_line_end), 256'd0);
        chk({tag, "_frame_end"},256'(o_frame_end), 256'd0);
        chk({tag, "_rreq"},     256'(ddr_rreq), 256'd0);
        chk({tag, "_raddr"},    256'(ddr_raddr), 256'd0);
        chk({tag, "_rd_len"},   256'(ddr_rd_len), 256'd0);
        chk({tag, "_err"},      256'(o_err), 256'd0);
    endtask

    initial begin
        logic [127:0] snap;
        logic         seen;
        logic         stable;
        logic         found;
        int           base;

        ddr_rstn = 1'b0; frame_start = 1'b0; frame_sel = 2'd0; ddr_rrdy = 1'b1;
        ddr_rdone = 1'b0; ddr_rdata = '0; ddr_rdata_en = 1'b0; i_data_ready = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        ddr_rstn = 1'b1;
        tick();

        // basic frame from slot 1
        base = rx_cnt;
        pulse_start(2'd1);
        chk("rreq_rise", 256'(ddr_rreq), 256'd1);
        for (int l = 0; l < 3; l++) begin
            req_phase(27'h100000 + 27'(l * 32), 0);
            beats_phase(4, l, 1'b1);
        end
        wait_drain();
        chk("basic_words", 256'(rx_cnt - base), 256'd24);
        chk("basic_err", 256'(o_err), 256'd0);
        idle_check(10);

        // back-pressure: only two lines may be fetched while nothing drains
        i_data_ready = 1'b0;
        base = rx_cnt;
        pulse_start(2'd2);
        req_phase(27'h200000, 0);
        beats_phase(4, 0, 1'b1);
        req_phase(27'h200020, 0);
        beats_phase(4, 1, 1'b1);
        repeat (2) tick();
        chk("bp_valid", 256'(o_data_valid), 256'd1);
        snap = o_data; seen = 1'b0; stable = 1'b1;
        repeat (30) begin
            tick();
            if (ddr_rreq) seen = 1'b1;
            if (o_data !== snap || o_data_valid !== 1'b1 || o_line_end !== 1'b0) stable = 1'b0;
        end
        chk("bp_no_third_req", 256'(seen), 256'd0);
        chk("bp_hold_stable", 256'(stable), 256'd1);
        i_data_ready = 1'b1;
        base = rx_cnt;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (ddr_rreq) found = 1'b1;
            else tick();
        end
        chk("bp_req_after_drain", 256'((rx_cnt - base) >= 8), 256'd1);
        req_phase(27'h200040, 0);
        beats_phase(4, 2, 1'b1);
        wait_drain();

        // request hold with ddr_rrdy low for 5 cycles
        ddr_rrdy = 1'b0;
        pulse_start(2'd3);
        req_phase(27'h300000, 5);
        beats_phase(4, 0, 1'b1);
        req_phase(27'h300020, 0);
        beats_phase(4, 1, 1'b1);
        req_phase(27'h300040, 0);
        beats_phase(4, 2, 1'b1);
        wait_drain();

        // abort after 2 of 4 beats, new frame in slot 1
        pulse_start(2'd0);
        req_phase(27'h000000, 0);
        for (int k = 0; k < 2; k++) begin
            ddr_rdata = mk_beat(beat_id); beat_id++; ddr_rdata_en = 1'b1; tick();
        end
        ddr_rdata_en = 1'b0;
        pulse_start(2'd1);
        for (int k = 0; k < 2; k++) begin
            ddr_rdata = mk_beat(beat_id); beat_id++; ddr_rdata_en = 1'b1; tick();
        end
        ddr_rdata_en = 1'b0;
        chk("drain_no_req", 256'(ddr_rreq), 256'd0);
        ddr_rdone = 1'b1;
        tick();
        ddr_rdone = 1'b0;
        for (int l = 0; l < 3; l++) begin
            req_phase(27'h100000 + 27'(l * 32), 0);
            beats_phase(4, l, 1'b1);
        end
        wait_drain();
        chk("abort_err", 256'(o_err), 256'd0);

        // error flags: overflow then short line
        base = rx_cnt;
        pulse_start(2'd1);
        req_phase(27'h100000, 0);
        beats_phase(5, 0, 1'b1);
        chk("err_overflow", 256'(o_err), 256'd1);
        req_phase(27'h100020, 0);
        beats_phase(3, 1, 1'b1);
        chk("err_short", 256'(o_err), 256'd3);
        req_phase(27'h100040, 0);
        beats_phase(4, 2, 1'b1);
        wait_drain();
        chk("err_words", 256'(rx_cnt - base), 256'd24);

        // reset in the middle of a read, with a frame_start that must be ignored
        pulse_start(2'd2);
        chk("err_cleared", 256'(o_err), 256'd0);
        req_phase(27'h200000, 0);
        for (int k = 0; k < 2; k++) begin
            ddr_rdata = mk_beat(beat_id); beat_id++; ddr_rdata_en = 1'b1; tick();
        end
        ddr_rdata_en = 1'b0;
        ddr_rstn = 1'b0;
        frame_start = 1'b1;
        tick();
        ddr_rstn = 1'b1;
        frame_start = 1'b0;
        chk_all_zero("midreset");
        idle_check(20);
        chk("final_queue_empty", 256'(sb.size()), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
